// File: rtl/vote_collector.sv
// Front-end for the four-input majority voter: synchronises and debounces the voter
// buttons, runs a timed voting window and holds the latched ballot on a..d.
module vote_collector #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES   = 1000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_a,
    input  logic       btn_b,
    input  logic       btn_c,
    input  logic       btn_d,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       window_open,
    output logic       done,
    output logic [2:0] vote_count
);

    typedef enum logic [1:0] {IDLE, OPEN, CLOSED} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYCLES - 1);

    state_t           state;
    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [3:0]       deb_q;
    logic [3:0]       press;
    logic [3:0]       vote;
    logic [3:0]       nxt_vote;
    logic [CNT_W-1:0] dcnt [4];
    logic [CNT_W-1:0] timer;

    // Bit 0 is voter A, bit 3 is voter D.
    assign raw = {btn_d, btn_c, btn_b, btn_a};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb   <= '0;
            deb_q <= '0;
            for (int unsigned i = 0; i < 4; i++) dcnt[i] <= '0;
        end else begin
            deb_q <= deb;
            for (int unsigned i = 0; i < 4; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (dcnt[i] == DEB_LAST) begin
                        deb[i]  <= sync2[i];
                        dcnt[i] <= '0;
                    end else begin
                        dcnt[i] <= dcnt[i] + CNT_W'(1);
                    end
                end else begin
                    dcnt[i] <= '0;
                end
            end
        end
    end

    // A level already high when the window opens never produces a press.
    assign press    = deb & ~deb_q;
    assign nxt_vote = vote | press;

    function automatic logic [2:0] popcount(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int unsigned i = 0; i < 4; i++) n = n + 3'(v[i]);
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            vote        <= '0;
            vote_count  <= '0;
            window_open <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE, CLOSED: begin
                    if (start) begin
                        state       <= OPEN;
                        timer       <= WIN_LOAD;
                        vote        <= '0;
                        vote_count  <= '0;
                        window_open <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                OPEN: begin
                    vote       <= nxt_vote;
                    vote_count <= popcount(nxt_vote);
                    timer      <= timer - CNT_W'(1);
                    // Early close looks at the registered latches, so it lands one clock after the fourth vote.
                    if (timer == '0 || (&vote)) begin
                        state       <= CLOSED;
                        window_open <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    window_open <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

    assign a = vote[0];
    assign b = vote[1];
    assign c = vote[2];
    assign d = vote[3];

endmodule
